// File: rtl/regfile_read_stage.sv
// Operand fetch stage for the 32-entry integer register file: selects operands
// with write-back bypass, tracks pending writes in a busy scoreboard, and
// registers the result for the issue side.
module regfile_read_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_WIDTH-1:0]          in_rs1,
    input  logic [ADDR_WIDTH-1:0]          in_rs2,
    input  logic [ADDR_WIDTH-1:0]          in_rd,
    input  logic                           in_rd_we,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] rf_q,
    input  logic                           wb_en,
    input  logic [ADDR_WIDTH-1:0]          wb_addr,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_op1,
    output logic [DATA_WIDTH-1:0]          out_op2,
    output logic [ADDR_WIDTH-1:0]          out_rd,
    output logic                           out_rd_we,
    output logic [NUM_REGS-1:0]            busy_o
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  r_state;
    logic [NUM_REGS-1:0]     r_busy;
    logic [DATA_WIDTH-1:0]   r_op1;
    logic [DATA_WIDTH-1:0]   r_op2;
    logic [ADDR_WIDTH-1:0]   r_rd;
    logic                    r_rd_we;

    logic [DATA_WIDTH-1:0]   w_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0]   w_op1;
    logic [DATA_WIDTH-1:0]   w_op2;
    logic [NUM_REGS-1:0]     w_busy_next;
    logic                    w_clr_rs1;
    logic                    w_clr_rs2;
    logic                    w_clr_rd;
    logic                    w_hazard;
    logic                    w_accept;

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            w_regs[k] = rf_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // A write-back landing this cycle both forwards its data and releases the busy bit.
    assign w_clr_rs1 = wb_en && (wb_addr == in_rs1);
    assign w_clr_rs2 = wb_en && (wb_addr == in_rs2);
    assign w_clr_rd  = wb_en && (wb_addr == in_rd);

    always_comb begin
        w_op1 = '0;
        w_op2 = '0;
        if (in_rs1 != '0) begin
            w_op1 = w_clr_rs1 ? wb_data : w_regs[in_rs1];
        end
        if (in_rs2 != '0) begin
            w_op2 = w_clr_rs2 ? wb_data : w_regs[in_rs2];
        end
    end

    assign w_hazard = in_valid &&
                      ((r_busy[in_rs1] && !w_clr_rs1) ||
                       (r_busy[in_rs2] && !w_clr_rs2) ||
                       (in_rd_we && r_busy[in_rd] && !w_clr_rd));

    assign in_ready = ((r_state == ST_EMPTY) || out_ready) && !w_hazard;
    assign w_accept = in_valid && in_ready;

    // Set is applied after clear so a same-address set/clear leaves the bit set.
    always_comb begin
        w_busy_next = r_busy;
        if (wb_en) begin
            w_busy_next[wb_addr] = 1'b0;
        end
        if (w_accept && in_rd_we && (in_rd != '0)) begin
            w_busy_next[in_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_op1   <= '0;
            r_op2   <= '0;
            r_rd    <= '0;
            r_rd_we <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op1   <= w_op1;
                r_op2   <= w_op2;
                r_rd    <= in_rd;
                r_rd_we <= in_rd_we;
            end
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready && !w_accept) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_op1   = r_op1;
    assign out_op2   = r_op2;
    assign out_rd    = r_rd;
    assign out_rd_we = r_rd_we;
    assign busy_o    = r_busy;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Scoreboard bench for regfile_read_stage: accepted instructions push expected
// packets, output handshakes pop and compare them.
module tb_regfile_read_stage;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [4:0]    in_rd;
    logic          in_rd_we;
    logic [1023:0] rf_q;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_op1;
    logic [31:0]   out_op2;
    logic [4:0]    out_rd;
    logic          out_rd_we;
    logic [31:0]   busy_o;

    logic [31:0]   rfModel [32];

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rdWe;
    } pkt_t;

    pkt_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    logic lastAccepted;

    regfile_read_stage #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .NUM_REGS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_rs1(in_rs1),
        .in_rs2(in_rs2),
        .in_rd(in_rd),
        .in_rd_we(in_rd_we),
        .rf_q(rf_q),
        .wb_en(wb_en),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_op1(out_op1),
        .out_op2(out_op2),
        .out_rd(out_rd),
        .out_rd_we(out_rd_we),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < 32; k++) begin
            rf_q[k*32 +: 32] = rfModel[k];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] expectOperand(input logic [4:0] rs);
        if (rs == 5'd0) return 32'h0;
        if (wb_en && (wb_addr == rs)) return wb_data;
        return rfModel[rs];
    endfunction

    // Waits for the next rising edge, then drives a new instruction slightly after it.
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic we);
        @(posedge clk);
        #2;
        in_valid = v;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
        in_rd_we = we;
    endtask

    task automatic setWriteBack(input logic en, input logic [4:0] addr, input logic [31:0] data);
        wb_en   = en;
        wb_addr = addr;
        wb_data = data;
    endtask

    // Output handshake pops first, then an accept pushes the next expected packet.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_packet", {63'd0, out_valid}, 64'd0);
                end else begin
                    pkt_t p;
                    p = expQ.pop_front();
                    checkOutput("sb_op1", {32'd0, out_op1}, {32'd0, p.op1});
                    checkOutput("sb_op2", {32'd0, out_op2}, {32'd0, p.op2});
                    checkOutput("sb_rd", {59'd0, out_rd}, {59'd0, p.rd});
                    checkOutput("sb_rd_we", {63'd0, out_rd_we}, {63'd0, p.rdWe});
                end
            end
            if (in_valid && in_ready) begin
                pkt_t n;
                n.op1  = expectOperand(in_rs1);
                n.op2  = expectOperand(in_rs2);
                n.rd   = in_rd;
                n.rdWe = in_rd_we;
                expQ.push_back(n);
            end
        end
    end

    initial begin
        for (int k = 0; k < 32; k++) begin
            rfModel[k] = 32'h1000_0000 + k * 32'h0101_0111;
        end
        rfModel[2] = 32'h7FFF_EFFC;
        rfModel[3] = 32'hA5A5_A5A5;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_rd     = '0;
        in_rd_we  = 1'b0;
        out_ready = 1'b1;
        setWriteBack(1'b0, 5'd0, 32'h0);

        // reset, then a plain read of register 2
        repeat (3) begin
            @(negedge clk);
            checkOutput("reset_busy", {32'd0, busy_o}, 64'd0);
            checkOutput("reset_valid", {63'd0, out_valid}, 64'd0);
        end
        checkOutput("reset_op1", {32'd0, out_op1}, 64'd0);
        applyStimulus(1'b1, 5'd2, 5'd0, 5'd5, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("first_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("first_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("first_op1", {32'd0, out_op1}, 64'h7FFF_EFFC);
        checkOutput("first_op2", {32'd0, out_op2}, 64'd0);
        checkOutput("first_rd", {59'd0, out_rd}, 64'd5);
        checkOutput("first_busy5", {63'd0, busy_o[5]}, 64'd1);

        // RAW on register 5, released by a same-cycle write-back
        applyStimulus(1'b1, 5'd5, 5'd1, 5'd6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #2;
            end
            @(negedge clk);
            checkOutput("raw_stall", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #2;
        setWriteBack(1'b1, 5'd5, 32'h0000_1234);
        @(negedge clk);
        checkOutput("raw_release", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        setWriteBack(1'b0, 5'd0, 32'h0);
        rfModel[5] = 32'h0000_1234;
        @(negedge clk);
        checkOutput("raw_op1", {32'd0, out_op1}, 64'h1234);
        checkOutput("raw_busy5", {63'd0, busy_o[5]}, 64'd0);

        // backpressure: packet must hold while a later write-back hits its source
        applyStimulus(1'b1, 5'd3, 5'd4, 5'd8, 1'b0);
        @(negedge clk);
        checkOutput("bp_first_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b1, 5'd10, 5'd11, 5'd12, 1'b1);
        out_ready = 1'b0;
        setWriteBack(1'b1, 5'd3, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #2;
            end
            @(negedge clk);
            checkOutput("bp_ready", {63'd0, in_ready}, 64'd0);
            checkOutput("bp_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("bp_hold_op1", {32'd0, out_op1}, 64'hA5A5_A5A5);
        end
        @(posedge clk);
        #2;
        rfModel[3] = 32'hDEAD_BEEF;
        setWriteBack(1'b0, 5'd0, 32'h0);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_accept", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("bp_next_valid", {63'd0, out_valid}, 64'd1);
        checkOutput("bp_next_op1", {32'd0, out_op1}, {32'd0, rfModel[10]});
        checkOutput("bp_busy12", {63'd0, busy_o[12]}, 64'd1);
        @(posedge clk);
        #2;
        setWriteBack(1'b1, 5'd12, 32'h0000_0C0C);
        @(posedge clk);
        #2;
        setWriteBack(1'b0, 5'd0, 32'h0);
        rfModel[12] = 32'h0000_0C0C;
        @(negedge clk);
        checkOutput("wb_clear12", {63'd0, busy_o[12]}, 64'd0);

        // register 0: never busy, always reads zero
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        applyStimulus(1'b1, 5'd0, 5'd2, 5'd13, 1'b0);
        setWriteBack(1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("r0_busy0", {63'd0, busy_o[0]}, 64'd0);
        checkOutput("r0_ready", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        setWriteBack(1'b0, 5'd0, 32'h0);
        @(negedge clk);
        checkOutput("r0_op1", {32'd0, out_op1}, 64'd0);
        checkOutput("r0_busy_after_wb", {63'd0, busy_o[0]}, 64'd0);

        // WAW on register 7 with simultaneous set and clear
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd7, 1'b1);
        applyStimulus(1'b1, 5'd4, 5'd6, 5'd7, 1'b1);
        @(negedge clk);
        checkOutput("waw_stall0", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #2;
        @(negedge clk);
        checkOutput("waw_stall1", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #2;
        setWriteBack(1'b1, 5'd7, 32'h0000_0077);
        @(negedge clk);
        checkOutput("waw_accept", {63'd0, in_ready}, 64'd1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        setWriteBack(1'b0, 5'd0, 32'h0);
        rfModel[7] = 32'h0000_0077;
        @(negedge clk);
        checkOutput("waw_busy7", {63'd0, busy_o[7]}, 64'd1);
        checkOutput("waw_rd", {59'd0, out_rd}, 64'd7);

        // random traffic with random backpressure, no destination writes
        lastAccepted = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (lastAccepted || !in_valid) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_rs1   = 5'($urandom_range(14, 31));
                in_rs2   = 5'($urandom_range(14, 31));
                in_rd    = 5'($urandom_range(14, 31));
                in_rd_we = 1'b0;
            end
            out_ready = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            lastAccepted = in_valid && in_ready;
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        // asynchronous reset while full with pending writes
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        applyStimulus(1'b1, 5'd2, 5'd1, 5'd9, 1'b1);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        out_ready = 1'b0;
        checkOutput("pre_reset_busy", {62'd0, busy_o[9], busy_o[3]}, 64'd3);
        checkOutput("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        #1;
        rst = 1'b0;
        expQ.delete();
        #1;
        checkOutput("async_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("async_busy", {32'd0, busy_o}, 64'd0);
        checkOutput("async_rd", {59'd0, out_rd}, 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_valid", {63'd0, out_valid}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_read_stage.md
Name: regfile_read_stage

Overview:
- Read-side operand fetch stage for the 32-entry integer register file in the dispatch path.
- Accepts decoded instructions (rs1/rs2/rd) over a valid/ready handshake and selects operands from the register file's flattened Q outputs.
- Bypasses same-cycle write-back data and keeps a one-bit-per-register busy scoreboard so RAW and WAW hazards stall.
- Presents registered operands to the issue side over a second valid/ready handshake.

Parameters:
DATA_WIDTH, 32, operand/register width
ADDR_WIDTH, 5, register address width
NUM_REGS, 32, register count (must equal 2**ADDR_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts instruction this cycle
in_rs1  input  ADDR_WIDTH  source register 1 address
in_rs2  input  ADDR_WIDTH  source register 2 address
in_rd  input  ADDR_WIDTH  destination register address
in_rd_we  input  1  instruction writes in_rd
rf_q  input  NUM_REGS*DATA_WIDTH  register file contents; register k at [k*DATA_WIDTH +: DATA_WIDTH]
wb_en  input  1  write-back this cycle (same strobe that drives the register file enable)
wb_addr  input  ADDR_WIDTH  write-back register address
wb_data  input  DATA_WIDTH  write-back data
out_valid  output  1  operand packet valid
out_ready  input  1  downstream accepts packet
out_op1  output  DATA_WIDTH  operand 1
out_op2  output  DATA_WIDTH  operand 2
out_rd  output  ADDR_WIDTH  destination address
out_rd_we  output  1  destination write flag
busy_o  output  NUM_REGS  scoreboard; bit k set means a write to register k is pending

Behaviour:
- Reset (rst=0, asynchronous):
  - State EMPTY; out_valid=0.
  - out_op1, out_op2, out_rd and out_rd_we are all 0.
  - busy all 0.
  - Release is synchronous to clk.
- FSM has two states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on out_ready with no accept.
  - FULL -> FULL on out_ready with accept (back-to-back), or on out_ready=0 (hold).
- Register 0:
  - Reads as 0 regardless of rf_q or wb.
  - busy[0] is never set.
  - A write-back to 0 has no effect on the scoreboard.
- Bypass, for each source s:
  - clr_s = wb_en && wb_addr==s.
  - Value = 0 if s==0; else wb_data if clr_s; else rf_q[s].
- Hazard = in_valid && any of:
  - busy[rs1] && !clr_rs1
  - busy[rs2] && !clr_rs2
  - in_rd_we && busy[rd] && !clr_rd (WAW)
- Ready and accept:
  - in_ready = (EMPTY || out_ready) && !hazard. in_ready is combinational and may depend on in_rs1/in_rs2/in_rd.
  - Accept = in_valid && in_ready.
- On accept, at the next edge:
  - Capture operands, rd and rd_we; out_valid=1. Latency is 1 cycle.
- While FULL && !out_ready:
  - All outputs hold stable.
  - Later write-backs do not alter captured operands.
- Scoreboard, per edge:
  - wb_en clears busy[wb_addr].
  - Accept with in_rd_we && in_rd!=0 sets busy[in_rd].
  - Set and clear on the same address in the same cycle: set wins.
- Held state on stall:
  - The stage holds no state for stalled instructions.
  - The upstream must keep in_* stable while in_valid && !in_ready.
- Reset mid-operation:
  - The in-flight packet is dropped and all busy bits are cleared immediately (asynchronous).

Test Plan:
- Reset then SP read:
  - Stimulus: rst low 3 cycles; release; rf_q reg2=0x7FFF_EFFC; issue rs1=2, rs2=0, rd=5, rd_we=1.
  - Required: busy_o=0 during reset. Next cycle out_valid=1, out_op1=0x7FFF_EFFC, out_op2=0, out_rd=5, busy_o[5]=1.
- RAW stall and bypass:
  - Stimulus: busy[5]=1; issue rs1=5 -> in_ready=0 for 3 cycles. Then wb_en=1, wb_addr=5, wb_data=0x0000_1234.
  - Required: in_ready=1 that same cycle. Next cycle out_op1=0x1234 and busy_o[5]=0.
- Backpressure:
  - Stimulus: FULL with out_op1=0xA5A5_A5A5, out_ready=0, new valid instruction -> in_ready=0 and outputs unchanged for 4 cycles. Then out_ready=1.
  - Required: the new instruction is accepted that cycle and its operands appear next cycle with out_valid still 1.
- Register 0:
  - Stimulus: issue rd=0, rd_we=1.
  - Required: busy_o[0]=0.
  - Stimulus: wb_en, wb_addr=0, wb_data=0xFFFF_FFFF with rs1=0.
  - Required: out_op1=0.
- WAW with simultaneous set/clear:
  - Stimulus: busy[7]=1; issue rd=7, rd_we=1 without wb -> stall. Then wb_addr=7 in the same cycle.
  - Required: accept, and busy_o[7]=1 afterwards (set wins).
- Async reset mid-operation:
  - Stimulus: FULL with busy[3], busy[9] set; pull rst low between clock edges.
  - Required: out_valid=0 and busy_o=0 immediately, before the next clk edge.
